// File: rtl/keypad_scan_controller.sv
// rtl/keypad_scan_controller.sv - 4x3 keypad row scanner with frame debounce and valid/ack key output
module keypad_scan_controller #(
    parameter int SETTLE   = 2,
    parameter int DEBOUNCE = 4
) (
    input  logic       scanClock,
    input  logic       reset,
    input  logic [2:0] columns,
    output logic [3:0] rows,
    output logic [3:0] keyCode,
    output logic       keyValid,
    input  logic       keyAck,
    output logic       keyHeld,
    output logic       overrun
);
    typedef enum logic [1:0] {IDLE, PRESS_CAND, HELD, RELEASE_CAND} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] DEB         = 4'(DEBOUNCE);

    state_t     state_q, state_d;
    logic [1:0] row_idx_q, row_idx_d;
    logic [3:0] dwell_q, dwell_d;
    logic       acc_any_q, acc_any_d;
    logic       acc_multi_q, acc_multi_d;
    logic [3:0] acc_code_q, acc_code_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] rows_q, rows_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;
    logic       key_held_q, key_held_d;
    logic       overrun_q, overrun_d;

    logic       sample_edge, frame_close;
    logic       col_any, col_multi;
    logic [1:0] col_idx;
    logic [3:0] sample_code;
    logic       merged_any, merged_multi;
    logic [3:0] merged_code;
    logic       res_none, res_single;
    logic       press_evt, ack_take;

    always_comb begin
        sample_edge = (dwell_q == SETTLE_LAST);
        frame_close = sample_edge && (row_idx_q == 2'd3);

        col_any   = |columns;
        col_multi = (columns[0] & columns[1]) | (columns[0] & columns[2]) | (columns[1] & columns[2]);
        col_idx   = columns[0] ? 2'd0 : (columns[1] ? 2'd1 : 2'd2);

        // Rows 0..2 hold digits 1..9 in reading order; the bottom row is *, 0, #.
        if (row_idx_q != 2'd3) begin
            sample_code = {2'b00, row_idx_q} * 4'd3 + {2'b00, col_idx} + 4'd1;
        end else begin
            case (col_idx)
                2'd0:    sample_code = 4'hA;
                2'd1:    sample_code = 4'h0;
                default: sample_code = 4'hB;
            endcase
        end

        merged_any   = acc_any_q | col_any;
        merged_multi = acc_multi_q | col_multi | (acc_any_q & col_any);
        merged_code  = acc_any_q ? acc_code_q : sample_code;
        res_none     = !merged_any;
        res_single   = merged_any && !merged_multi;

        state_d     = state_q;
        row_idx_d   = row_idx_q;
        dwell_d     = dwell_q;
        acc_any_d   = acc_any_q;
        acc_multi_d = acc_multi_q;
        acc_code_d  = acc_code_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        rows_d      = rows_q;
        press_evt   = 1'b0;

        if (sample_edge) begin
            dwell_d     = 4'd0;
            row_idx_d   = row_idx_q + 2'd1;
            rows_d      = 4'b0001 << row_idx_d;
            acc_any_d   = frame_close ? 1'b0 : merged_any;
            acc_multi_d = frame_close ? 1'b0 : merged_multi;
            acc_code_d  = frame_close ? 4'd0 : merged_code;
        end else begin
            dwell_d = dwell_q + 4'd1;
        end

        if (frame_close) begin
            case (state_q)
                IDLE: begin
                    if (res_single) begin
                        cand_d = merged_code;
                        cnt_d  = 4'd1;
                        if (DEB == 4'd1) begin
                            state_d   = HELD;
                            press_evt = 1'b1;
                        end else begin
                            state_d = PRESS_CAND;
                        end
                    end
                end
                PRESS_CAND: begin
                    if (res_single && merged_code == cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == DEB) begin
                            state_d   = HELD;
                            press_evt = 1'b1;
                        end
                    end else if (res_single) begin
                        cand_d = merged_code;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (res_none) begin
                        cnt_d   = 4'd1;
                        state_d = (DEB == 4'd1) ? IDLE : RELEASE_CAND;
                    end
                end
                default: begin
                    if (res_none) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == DEB) state_d = IDLE;
                    end else begin
                        state_d = HELD;
                    end
                end
            endcase
        end

        key_held_d = (state_d == HELD) || (state_d == RELEASE_CAND);

        // A press arriving with the same-edge ack replaces the pending key instead of overrunning.
        ack_take    = keyAck && key_valid_q;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        if (press_evt) begin
            if (!key_valid_q || ack_take) begin
                key_code_d  = cand_d;
                key_valid_d = 1'b1;
                overrun_d   = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (ack_take) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    always_ff @(posedge scanClock) begin
        if (reset) begin
            state_q     <= IDLE;
            row_idx_q   <= 2'd0;
            dwell_q     <= 4'd0;
            acc_any_q   <= 1'b0;
            acc_multi_q <= 1'b0;
            acc_code_q  <= 4'd0;
            cand_q      <= 4'd0;
            cnt_q       <= 4'd0;
            rows_q      <= 4'b0001;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            dwell_q     <= dwell_d;
            acc_any_q   <= acc_any_d;
            acc_multi_q <= acc_multi_d;
            acc_code_q  <= acc_code_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            rows_q      <= rows_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rows     = rows_q;
    assign keyCode  = key_code_q;
    assign keyValid = key_valid_q;
    assign keyHeld  = key_held_q;
    assign overrun  = overrun_q;
endmodule

// File: tb/tb_keypad_scan_controller.sv
// tb/tb_keypad_scan_controller.sv - directed bench for keypad_scan_controller with a keypad matrix model
module tb_keypad_scan_controller;
    logic        scan_clock;
    logic        reset;
    logic [2:0]  columns;
    logic [3:0]  rows;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        key_held;
    logic        overrun;
    logic [11:0] keys_down;
    int          checks;
    int          errors;

    keypad_scan_controller #(.SETTLE(2), .DEBOUNCE(4)) dut (
        .scanClock(scan_clock),
        .reset    (reset),
        .columns  (columns),
        .rows     (rows),
        .keyCode  (key_code),
        .keyValid (key_valid),
        .keyAck   (key_ack),
        .keyHeld  (key_held),
        .overrun  (overrun)
    );

    initial scan_clock = 1'b0;
    always #5 scan_clock = ~scan_clock;

    // Key index is row*3+col; a driven row connects its pressed keys onto the columns.
    always_comb begin
        columns = 3'b000;
        for (int r = 0; r < 4; r++) begin
            if (rows[r]) columns = columns | keys_down[r*3 +: 3];
        end
    end

    task automatic run_edges(input int n);
        repeat (n) begin
            @(posedge scan_clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        key_ack   = 1'b0;
        keys_down = 12'd0;
        run_edges(2);
        check("rst_rows", rows, 4'b0001);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", {3'b0, key_valid}, 4'd0);
        check("rst_held", {3'b0, key_held}, 4'd0);
        check("rst_overrun", {3'b0, overrun}, 4'd0);

        // Key 5 down from edge 1: accepted on edge 32.
        keys_down[4] = 1'b1;
        reset = 1'b0;
        run_edges(31);
        check("k5_valid_e31", {3'b0, key_valid}, 4'd0);
        run_edges(1);
        check("k5_valid_e32", {3'b0, key_valid}, 4'd1);
        check("k5_code", key_code, 4'h5);
        check("k5_held", {3'b0, key_held}, 4'd1);
        check("k5_rows_e32", rows, 4'b0001);
        key_ack = 1'b1;
        run_edges(1);
        check("k5_ack", {3'b0, key_valid}, 4'd0);
        key_ack = 1'b0;
        keys_down[4] = 1'b0;
        run_edges(30);
        check("k5_held_e63", {3'b0, key_held}, 4'd1);
        run_edges(1);
        check("k5_held_e64", {3'b0, key_held}, 4'd0);
        check("k5_no_second", {3'b0, key_valid}, 4'd0);

        // Key 8 bounces on alternating frames, then settles.
        for (int i = 0; i < 6; i++) begin
            keys_down[7] = (i % 2 == 0);
            run_edges(8);
            check("k8_bounce", {3'b0, key_valid}, 4'd0);
        end
        keys_down[7] = 1'b1;
        run_edges(31);
        check("k8_valid_e143", {3'b0, key_valid}, 4'd0);
        run_edges(1);
        check("k8_valid_e144", {3'b0, key_valid}, 4'd1);
        check("k8_code", key_code, 4'h8);
        key_ack = 1'b1;
        run_edges(1);
        key_ack = 1'b0;
        keys_down[7] = 1'b0;
        run_edges(31);
        check("k8_single_event", {3'b0, key_valid}, 4'd0);
        check("k8_released", {3'b0, key_held}, 4'd0);

        // Press * unacked, release, press #: overrun, code keeps *.
        keys_down[9] = 1'b1;
        run_edges(32);
        check("star_valid", {3'b0, key_valid}, 4'd1);
        check("star_code", key_code, 4'hA);
        keys_down[9] = 1'b0;
        run_edges(32);
        check("star_released", {3'b0, key_held}, 4'd0);
        keys_down[11] = 1'b1;
        run_edges(32);
        check("hash_code_kept", key_code, 4'hA);
        check("hash_overrun", {3'b0, overrun}, 4'd1);
        check("hash_valid", {3'b0, key_valid}, 4'd1);
        key_ack = 1'b1;
        run_edges(1);
        check("ovr_ack_valid", {3'b0, key_valid}, 4'd0);
        check("ovr_ack_overrun", {3'b0, overrun}, 4'd0);
        key_ack = 1'b0;
        keys_down[11] = 1'b0;
        run_edges(31);

        // Press 3 left pending, then press 6 with ack on its event edge: new key wins.
        keys_down[2] = 1'b1;
        run_edges(32);
        check("k3_code", key_code, 4'h3);
        keys_down[2] = 1'b0;
        run_edges(32);
        check("k3_still_pending", {3'b0, key_valid}, 4'd1);
        keys_down[5] = 1'b1;
        run_edges(31);
        key_ack = 1'b1;
        run_edges(1);
        check("k6_same_edge_valid", {3'b0, key_valid}, 4'd1);
        check("k6_same_edge_code", key_code, 4'h6);
        check("k6_same_edge_ovr", {3'b0, overrun}, 4'd0);
        run_edges(1);
        check("k6_acked", {3'b0, key_valid}, 4'd0);
        key_ack = 1'b0;
        keys_down[5] = 1'b0;
        run_edges(31);

        // 0 and # together produce multi frames; releasing # leaves 0 accepted.
        keys_down[10] = 1'b1;
        keys_down[11] = 1'b1;
        run_edges(40);
        check("multi_no_valid", {3'b0, key_valid}, 4'd0);
        check("multi_no_held", {3'b0, key_held}, 4'd0);
        keys_down[11] = 1'b0;
        run_edges(31);
        check("k0_valid_early", {3'b0, key_valid}, 4'd0);
        run_edges(1);
        check("k0_valid", {3'b0, key_valid}, 4'd1);
        check("k0_code", key_code, 4'h0);
        key_ack = 1'b1;
        run_edges(1);
        key_ack = 1'b0;
        keys_down[10] = 1'b0;
        run_edges(31);

        // Ack held high: each key visible for exactly one cycle.
        key_ack = 1'b1;
        keys_down[0] = 1'b1;
        run_edges(31);
        check("k1_pre", {3'b0, key_valid}, 4'd0);
        run_edges(1);
        check("k1_valid", {3'b0, key_valid}, 4'd1);
        check("k1_code", key_code, 4'h1);
        run_edges(1);
        check("k1_one_cycle", {3'b0, key_valid}, 4'd0);
        keys_down[0] = 1'b0;
        run_edges(31);
        keys_down[8] = 1'b1;
        run_edges(31);
        check("k9_pre", {3'b0, key_valid}, 4'd0);
        run_edges(1);
        check("k9_valid", {3'b0, key_valid}, 4'd1);
        check("k9_code", key_code, 4'h9);
        run_edges(1);
        check("k9_one_cycle", {3'b0, key_valid}, 4'd0);
        check("k9_code_holds", key_code, 4'h9);
        key_ack = 1'b0;
        keys_down[8] = 1'b0;
        run_edges(31);

        // Key 2 pending, reset while in release debounce.
        keys_down[1] = 1'b1;
        run_edges(32);
        check("k2_code", key_code, 4'h2);
        keys_down[1] = 1'b0;
        run_edges(9);
        check("rc_valid", {3'b0, key_valid}, 4'd1);
        check("rc_held", {3'b0, key_held}, 4'd1);
        reset = 1'b1;
        run_edges(1);
        check("mid_rst_rows", rows, 4'b0001);
        check("mid_rst_valid", {3'b0, key_valid}, 4'd0);
        check("mid_rst_held", {3'b0, key_held}, 4'd0);
        check("mid_rst_code", key_code, 4'h0);
        check("mid_rst_overrun", {3'b0, overrun}, 4'd0);
        reset = 1'b0;
        run_edges(5);
        check("scan_e5_rows", rows, 4'b0100);
        run_edges(1);
        check("scan_e6_rows", rows, 4'b1000);
        run_edges(1);
        check("scan_e7_rows", rows, 4'b1000);
        run_edges(1);
        check("scan_e8_rows", rows, 4'b0001);
        check("scan_e8_valid", {3'b0, key_valid}, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_scan_controller.md
# keypad_scan_controller

Sequencing controller for the 4x3 matrix keypad on the MACH64 board. It drives the row lines one at a time, samples the column receivers, and debounces complete scan frames. Each debounced key press is presented to downstream logic (digit buffer, seven-segment decoder) through a valid/ack handshake. It runs on the ripple-scaled 1 kHz scan clock and replaces free-running row sequencing with a press/hold/release-aware scheduler.

## Interface
- SETTLE, 2: scan clock cycles each row is driven; columns are sampled on the last cycle (legal 1..15).
- DEBOUNCE, 4: consecutive identical frames needed to accept a press or a release (legal 1..15).
- scanClock  in  1  scan clock, rising-edge active.
- reset  in  1  synchronous, active-high reset.
- columns  in  3  column receivers, active-high (board pulls down); bit 0 = left column (1,4,7,*), bit 2 = right column.
- rows  out  4  row drivers, one-hot active-high; bit 0 = top row (1,2,3), bit 3 = bottom row (*,0,#).
- keyCode  out  4  accepted key: digits 0–9 as BCD, * = 4'hA, # = 4'hB.
- keyValid  out  1  accepted key is pending.
- keyAck  in  1  consumer takes the pending key.
- keyHeld  out  1  debounced key is currently down.
- overrun  out  1  a press was dropped while keyValid was pending.

## Operation
- Reset values: rows=4'b0001, keyCode=0, keyValid=0, keyHeld=0, overrun=0; row index, dwell counter, frame accumulator, candidate and debounce counter all cleared.
- Scan: row r is driven for SETTLE cycles, then the index advances 0→1→2→3→0. Wrap-around is seamless, with no idle cycles. A frame is 4·SETTLE cycles.
- Sampling: on the last dwell edge of row r, columns are OR-ed into the frame accumulator with position (r, c). The accumulator records one of: none, single(code), or multi (two or more bits over the frame).
- Frame close is the sample edge of row 3. At that edge the frame result is evaluated and the accumulator is cleared for the next frame.
- Debounce FSM states: IDLE, PRESS_CAND, HELD, RELEASE_CAND.
  - IDLE: a single(code) result → PRESS_CAND with candidate=code, count=1. A none or multi result → stay.
  - PRESS_CAND: the same single(code) increments count. On reaching DEBOUNCE → HELD and a press event. A different single(code) restarts the count at 1 with the new candidate. A none or multi result → IDLE.
  - HELD: keyHeld=1. A none result → RELEASE_CAND with count=1. A single or multi result → stay; a second key or a rolled key never generates an event while held.
  - RELEASE_CAND: a none result increments count. On reaching DEBOUNCE → IDLE and keyHeld=0. Any non-none result → HELD.
  - With DEBOUNCE=1, IDLE goes straight to HELD and HELD goes straight to IDLE.
- Press event with keyValid=0: keyCode←candidate, keyValid←1.
- Press event with keyValid=1 and no keyAck on that edge: keyCode is unchanged and overrun←1.
- keyAck sampled high while keyValid=1: keyValid←0 and overrun←0 on that edge. keyAck while keyValid=0 is ignored.
- Press event and keyAck on the same edge: the new key wins. keyCode←candidate, keyValid stays 1, overrun←0.
- keyCode holds its last value after ack.
- Reset asserted mid-frame or mid-debounce discards everything. The pending key is lost and scanning restarts at row 0.

## Timing
- All outputs are registered and change only on rising scanClock edges.
- Edge numbering: edge 1 is the first edge with reset low.
- With defaults, frames close on edges 8, 16, 24, ….
- Press latency: a key down before edge 1 gives keyValid=1 after edge 8·DEBOUNCE (edge 32 with defaults). keyHeld rises on the same edge.
- Release latency: keyHeld falls on the close of the DEBOUNCE-th consecutive empty frame.
- Handshake: the consumer may hold keyAck high continuously. Each key is then visible for exactly one cycle.
- Worst-case press-to-valid: (DEBOUNCE+1) frames, when the key lands just after its row was sampled.

## Test plan
- Reset, hold key 5 (row 1, column 1) from edge 1 → keyValid=1, keyCode=4'h5, keyHeld=1 after edge 32. Release, then 4 empty frames → keyHeld=0. No second event.
- Key 8 bouncing (present/absent on alternating frames for 6 frames), then stable → exactly one event, keyCode=4'h8, valid 4 frames after the bouncing ends.
- Press *, no ack, release, press # → keyCode stays 4'hA and overrun=1. Then keyAck → keyValid=0 and overrun=0.
- Press 0 and # together from IDLE → no event. Release #, leaving 0 held → event with keyCode=4'h0 after 4 frames.
- keyAck held high throughout; press 1 then 9 → keyValid high for one cycle each, codes 4'h1 and 4'h9. The press and ack coincide on the same edge for 9.
- Assert reset during RELEASE_CAND with keyValid=1 → next cycle rows=4'b0001 and all outputs 0. Scan resumes, and row 3 is asserted on edges 7–8 after reset is released.
